// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game pattern datapath and its sequence memory.
package simon_pkg;

    localparam int PATTERN_W  = 4;
    localparam int SEQ_ADDR_W = 6;
    localparam int SEQ_DEPTH  = 1 << SEQ_ADDR_W;

    typedef logic [PATTERN_W-1:0] pattern_t;

    // True when an address selects an existing entry of a DEPTH-entry array.
    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/memory_if.sv
// Write/read port bundle of the pattern sequence memory.
interface memory_if #(
    parameter int DATA_W = simon_pkg::PATTERN_W,
    parameter int ADDR_W = simon_pkg::SEQ_ADDR_W
);
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_en;
    logic [DATA_W-1:0] r_data;

    modport master (
        output r_addr, w_addr, w_data, w_en,
        input  r_data
    );

    modport slave (
        input  r_addr, w_addr, w_data, w_en,
        output r_data
    );
endinterface

// File: rtl/memory.sv
// Pattern sequence register file: one synchronous write port, one combinational
// read port. Built from flops so the whole array clears asynchronously.
module memory
    import simon_pkg::*;
#(
    parameter int DATA_W = PATTERN_W,
    parameter int ADDR_W = SEQ_ADDR_W,
    parameter int DEPTH  = SEQ_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    memory_if.slave  bus
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              w_ok;
    logic              r_ok;

    // Out-of-range addresses are rejected rather than wrapped onto real entries.
    assign w_ok = addr_in_range(32'(bus.w_addr), DEPTH);
    assign r_ok = addr_in_range(32'(bus.r_addr), DEPTH);

    // Array storage: async clear on rst low, otherwise write the addressed entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.w_en && w_ok) begin
            mem[bus.w_addr] <= bus.w_data;
        end
    end

    // Read mux; reset gating keeps r_data at zero for the whole reset window.
    assign bus.r_data = (rst && r_ok) ? mem[bus.r_addr] : '0;

endmodule

// File: tb/tb_memory.sv
// Directed bench for the pattern sequence memory with a queue-based scoreboard.
module tb_memory;
    import simon_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [3:0] model [64];
    logic [3:0] exp_q [$];

    memory_if #(.DATA_W(4), .ADDR_W(6)) bus ();

    memory #(.DATA_W(4), .ADDR_W(6), .DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Drive a write at the falling edge and let it land on the next rising edge.
    task automatic do_write(input logic [5:0] a, input logic [3:0] d);
        @(negedge clk);
        bus.w_addr = a;
        bus.w_data = d;
        bus.w_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.w_en   = 1'b0;
        if (rst) model[a] = d;
    endtask

    task automatic expect_val(input string tag, input logic [3:0] d);
        exp_q.push_back(d);
    endtask

    // Compare the oldest expected value against what the DUT shows right now.
    task automatic compare(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, observed %b", tag, bus.r_data);
            return;
        end
        e = exp_q.pop_front();
        n_cmp++;
        assert (bus.r_data === e)
        else begin
            n_bad++;
            $error("FAIL %s: addr %0d observed %b expected %b", tag, bus.r_addr, bus.r_data, e);
        end
    endtask

    task automatic check_read(input string tag, input logic [5:0] a);
        bus.r_addr = a;
        #1;
        expect_val(tag, model[a]);
        compare(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 64; i++) model[i] = 4'b0000;
        bus.r_addr = '0;
        bus.w_addr = '0;
        bus.w_data = '0;
        bus.w_en   = 1'b0;
        rst        = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_read("reset_a0", 6'd0);
        check_read("reset_a63", 6'd63);
        @(negedge clk);
        rst = 1'b1;

        // reset clear
        for (int i = 0; i < 64; i++) do_write(6'(i), 4'b1000);
        check_read("prefill_a17", 6'd17);
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 4'b0000;
        bus.r_addr = 6'd17;
        #1;
        expect_val("clear_low", 4'b0000);
        compare("clear_low");
        #1;
        rst = 1'b1;
        for (int i = 0; i < 64; i++) check_read("clear_sweep", 6'(i));

        // basic write/read
        do_write(6'd0,  4'b0001);
        do_write(6'd1,  4'b0010);
        do_write(6'd2,  4'b0100);
        do_write(6'd63, 4'b1000);
        check_read("basic_a0", 6'd0);
        check_read("basic_a1", 6'd1);
        check_read("basic_a2", 6'd2);
        check_read("basic_a63", 6'd63);
        check_read("basic_a3", 6'd3);

        // write enable low
        do_write(6'd5, 4'b0100);
        @(negedge clk);
        bus.w_addr = 6'd5;
        bus.w_data = 4'b0001;
        bus.w_en   = 1'b0;
        @(posedge clk);
        #1;
        check_read("wen_low", 6'd5);

        // same-address read/write
        do_write(6'd10, 4'b0010);
        @(negedge clk);
        bus.r_addr = 6'd10;
        bus.w_addr = 6'd10;
        bus.w_data = 4'b1000;
        bus.w_en   = 1'b1;
        #1;
        expect_val("same_before", 4'b0010);
        compare("same_before");
        @(posedge clk);
        #1;
        bus.w_en = 1'b0;
        expect_val("same_after", 4'b1000);
        compare("same_after");
        model[10] = 4'b1000;

        // reset mid-operation
        do_write(6'd7, 4'b0100);
        check_read("mid_pre", 6'd7);
        @(negedge clk);
        bus.w_addr = 6'd7;
        bus.w_data = 4'b0001;
        bus.w_en   = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 4'b0000;
        @(posedge clk);
        #1;
        check_read("mid_during", 6'd7);
        @(negedge clk);
        rst = 1'b1;
        bus.w_en = 1'b0;
        #1;
        check_read("mid_after", 6'd7);
        @(negedge clk);
        bus.w_addr = 6'd7;
        bus.w_data = 4'b0001;
        bus.w_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.w_en = 1'b0;
        model[7] = 4'b0001;
        check_read("mid_first_write", 6'd7);

        // sequence fill
        for (int i = 0; i < 64; i++) do_write(6'(i), 4'(1 << (i % 4)));
        for (int i = 0; i < 64; i++) check_read("fill", 6'(i));

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
